// File: rtl/rgmii_sniffer_pkg.sv
// Shared types and constants for the RGMII/MII nibble sniffer.
package rgmii_sniffer_pkg;

    // Receive framing states
    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_t;

    // Preamble and start-of-frame delimiter nibbles as seen on the wire
    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    // One UART character: start bit, 8 data bits, stop bit
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/rgmii_nibble_sniffer_uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte handshake.
// A byte is accepted when valid && ready; ready is high only while idle,
// so the next byte can be taken on the clk right after the stop bit ends.
module uart_tx_8n1
    import rgmii_sniffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       SW0,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(UART_FRAME_BITS - 1);

    logic          busy;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    // Remaining data bits plus the stop bit; shifted right as bits go out
    logic [8:0]    shreg;

    assign ready = ~busy;

    // Bit timing and serialisation; tx is a flop so the line never glitches
    always_ff @(posedge clk) begin
        if (SW0) begin
            busy    <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            tx      <= 1'b1;
        end else if (!busy) begin
            tx <= 1'b1;
            if (valid) begin
                busy    <= 1'b1;
                clk_cnt <= '0;
                bit_idx <= '0;
                shreg   <= {1'b1, data};
                tx      <= 1'b0;
            end
        end else if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
                busy <= 1'b0;
                tx   <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rgmii_nibble_sniffer.sv
// RGMII/MII receive sniffer: oversamples a single-edge nibble stream,
// strips preamble/SFD, queues frame bytes in a FIFO and streams them out
// over an 8N1 UART. LED[6:0] counts good frames, LED[7] flags overflow.
module rgmii_nibble_sniffer
    import rgmii_sniffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic       clk,
    input  logic       SW0,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] LED,
    input  logic       rgm0_en,
    input  logic       rgm0_clk,
    input  logic [3:0] rgm0_d
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // The receive side of the UART is not used by this design
    logic unused_rx;
    assign unused_rx = uart_rx;

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    logic       clk_s1, clk_s2, clk_s3;
    logic       en_s1, en_s2;
    logic [3:0] d_s1, d_s2;
    logic       strobe;

    // Two-flop synchronisers for all pins, plus one extra stage for edge detect
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (SW0) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            clk_s3 <= 1'b0;
            en_s1  <= 1'b0;
            en_s2  <= 1'b0;
            d_s1   <= '0;
            d_s2   <= '0;
        end else begin
            clk_s1 <= rgm0_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            en_s1  <= rgm0_en;
            en_s2  <= en_s1;
            d_s1   <= rgm0_d;
            d_s2   <= d_s1;
        end
    end

    // en/d are taken from the same stage as the rising-edge detect
    assign strobe = clk_s2 & ~clk_s3;

    // ------------------------------------------------------------------
    // Receive framing FSM
    // ------------------------------------------------------------------
    rx_state_t  state;
    logic       half;
    logic [3:0] lo;
    logic       got_byte;
    logic [6:0] frame_cnt;
    logic       push;
    logic [7:0] push_data;

    // Framing FSM; only advances on sample strobes
    always_ff @(posedge clk) begin
        if (SW0) begin
            state     <= IDLE;
            half      <= 1'b0;
            lo        <= '0;
            got_byte  <= 1'b0;
            frame_cnt <= '0;
        end else if (strobe) begin
            unique case (state)
                IDLE: begin
                    if (en_s2) begin
                        state <= (d_s2 == PREAMBLE_NIB) ? PRE : DROP;
                    end
                end
                PRE: begin
                    if (!en_s2) begin
                        state <= IDLE;
                    end else if (d_s2 == PREAMBLE_NIB) begin
                        state <= PRE;
                    end else if (d_s2 == SFD_NIB) begin
                        state    <= DATA;
                        half     <= 1'b0;
                        got_byte <= 1'b0;
                    end else begin
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (!en_s2) begin
                        // A dangling odd nibble disqualifies the frame
                        state <= IDLE;
                        half  <= 1'b0;
                        if (got_byte && !half) begin
                            frame_cnt <= frame_cnt + 7'd1;
                        end
                    end else if (!half) begin
                        lo   <= d_s2;
                        half <= 1'b1;
                    end else begin
                        half     <= 1'b0;
                        got_byte <= 1'b1;
                    end
                end
                DROP: begin
                    if (!en_s2) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Second nibble of a byte completes it; low nibble arrived first
    assign push      = strobe && (state == DATA) && en_s2 && half;
    assign push_data = {d_s2, lo};

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty;
    logic        pop, do_push;
    logic        overflow;
    logic        uart_ready;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = uart_ready && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = push && (!full || pop);

    // Pointer and overflow-flag update
    always_ff @(posedge clk) begin
        if (SW0) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define what is valid.
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // ------------------------------------------------------------------
    // UART output and status
    // ------------------------------------------------------------------
    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .SW0   (SW0),
        .data  (mem[rd_ptr[AW-1:0]]),
        .valid (!empty),
        .ready (uart_ready),
        .tx    (uart_tx)
    );

    assign LED = {overflow, frame_cnt};

endmodule

// File: tb/tb_rgmii_nibble_sniffer.sv
// Directed bench for rgmii_nibble_sniffer: drives nibble frames at 25 MHz
// against a 50 MHz clk, decodes uart_tx into a byte queue and compares
// against hand-built frames.
module tb_rgmii_nibble_sniffer;

    localparam int CPB   = 8;
    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       SW0 = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [7:0] LED;
    logic       rgm0_en = 1'b0;
    logic       rgm0_clk = 1'b0;
    logic [3:0] rgm0_d = 4'h0;

    int n_checks = 0;
    int n_bad    = 0;
    int frame_err = 0;

    logic [7:0] rx_q [$];
    logic [7:0] tx_bytes [$];

    rgmii_nibble_sniffer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .SW0      (SW0),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .LED      (LED),
        .rgm0_en  (rgm0_en),
        .rgm0_clk (rgm0_clk),
        .rgm0_d   (rgm0_d)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // UART decoder: mid-bit sampling; a character overlapping reset is dropped
    logic [9:0] mon_bits;
    logic       mon_abort;
    initial begin
        forever begin
            @(negedge clk);
            if (SW0 === 1'b0 && uart_tx === 1'b0) begin
                mon_abort = 1'b0;
                mon_bits  = '0;
                for (int b = 0; b < 10; b++) begin
                    repeat ((b == 0) ? CPB / 2 : CPB) begin
                        @(negedge clk);
                        if (SW0 !== 1'b0) mon_abort = 1'b1;
                    end
                    mon_bits[b] = uart_tx;
                end
                if (!mon_abort) begin
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) frame_err++;
                    rx_q.push_back(mon_bits[8:1]);
                end
            end
        end
    end

    // One 40 ns nibble period; data changes 5 ns before the rising edge
    task automatic send_nib(input logic en, input logic [3:0] d);
        rgm0_clk = 1'b0;
        #15;
        rgm0_en = en;
        rgm0_d  = d;
        #5;
        rgm0_clk = 1'b1;
        #20;
    endtask

    // Same as send_nib but pulses SW0 for exactly one clk posedge
    task automatic send_nib_rst(input logic en, input logic [3:0] d);
        rgm0_clk = 1'b0;
        #15;
        rgm0_en = en;
        rgm0_d  = d;
        SW0     = 1'b1;
        #5;
        rgm0_clk = 1'b1;
        #15;
        SW0 = 1'b0;
        #5;
    endtask

    task automatic send_pre_good();
        for (int i = 0; i < 15; i++) send_nib(1'b1, 4'h5);
        send_nib(1'b1, 4'hD);
    endtask

    // Bytes from tx_bytes[first..], optional trailing odd nibble, then en=0
    task automatic send_bytes(input int first, input bit extra);
        for (int i = first; i < tx_bytes.size(); i++) begin
            send_nib(1'b1, tx_bytes[i][3:0]);
            send_nib(1'b1, tx_bytes[i][7:4]);
        end
        if (extra) send_nib(1'b1, 4'hA);
        send_nib(1'b0, 4'h0);
    endtask

    // Idle nibbles until the UART has been quiet for 100 nibbles (bounded)
    task automatic wait_drain();
        int quiet = 0;
        int n = 0;
        int last = rx_q.size();
        while (quiet < 100 && n < 20000) begin
            send_nib(1'b0, 4'h0);
            n++;
            if (rx_q.size() != last) begin
                last  = rx_q.size();
                quiet = 0;
            end else begin
                quiet++;
            end
        end
        check("drain_done", 32'(quiet >= 100), 32'd1);
    endtask

    task automatic build_good();
        logic [7:0] hdr [14] = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24,
                                 8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc,
                                 8'h12, 8'h34};
        tx_bytes.delete();
        for (int i = 0; i < 14; i++) tx_bytes.push_back(hdr[i]);
        for (int i = 0; i < 46; i++) tx_bytes.push_back(8'(i * 7 + 3));
        tx_bytes.push_back(8'hde);
        tx_bytes.push_back(8'had);
        tx_bytes.push_back(8'hbe);
        tx_bytes.push_back(8'hef);
    endtask

    // Received bytes must equal the 64 sent bytes exactly
    task automatic check_good(input string tag);
        logic [31:0] got;
        check({tag, "_count"}, 32'(rx_q.size()), 32'd64);
        for (int i = 0; i < 64; i++) begin
            got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hffff_ffff;
            check({tag, "_byte"}, got, 32'(tx_bytes[i]));
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        int          last_idx;
        logic        in_order;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_led", 32'(LED), 32'h00);
        check("rst_tx", 32'(uart_tx), 32'd1);
        SW0 = 1'b0;
        #3;
        for (int i = 0; i < 100; i++) send_nib(1'b0, 4'h0);
        check("rst_fifo_empty", 32'(rx_q.size()), 32'd0);

        // Good frame
        build_good();
        rx_q.delete();
        send_pre_good();
        send_bytes(0, 1'b0);
        wait_drain();
        check_good("good");
        check("good_first", 32'(rx_q[0]), 32'h54);
        check("good_second", 32'(rx_q[1]), 32'hff);
        check("good_led", 32'(LED), 32'h01);

        // Bad preamble, then a good frame
        rx_q.delete();
        send_nib(1'b1, 4'h5);
        send_nib(1'b1, 4'h5);
        send_nib(1'b1, 4'h7);
        send_bytes(0, 1'b0);
        wait_drain();
        check("badpre_count", 32'(rx_q.size()), 32'd0);
        check("badpre_led", 32'(LED), 32'h01);
        send_pre_good();
        send_bytes(0, 1'b0);
        wait_drain();
        check_good("after_bad");
        check("after_bad_led", 32'(LED), 32'h02);

        // Odd trailing nibble: whole bytes out, frame not counted
        rx_q.delete();
        send_pre_good();
        send_bytes(0, 1'b1);
        wait_drain();
        check_good("odd");
        check("odd_led", 32'(LED), 32'h02);

        // Overflow: 200-byte frame whose byte value is its index
        tx_bytes.delete();
        for (int i = 0; i < 200; i++) tx_bytes.push_back(8'(i));
        rx_q.delete();
        send_pre_good();
        send_bytes(0, 1'b0);
        wait_drain();
        check("ovf_flag", 32'(LED[7]), 32'd1);
        check("ovf_more_than_depth", 32'(rx_q.size() > DEPTH), 32'd1);
        check("ovf_not_all", 32'(rx_q.size() < 200), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hffff_ffff;
            check("ovf_prefix", got, 32'(i));
        end
        last_idx = -1;
        in_order = 1'b1;
        foreach (rx_q[i]) begin
            if (int'(rx_q[i]) <= last_idx) in_order = 1'b0;
            last_idx = int'(rx_q[i]);
        end
        check("ovf_in_order", 32'(in_order), 32'd1);

        // Reset pulse during DA, then a good frame
        build_good();
        send_pre_good();
        send_nib(1'b1, tx_bytes[0][3:0]);
        send_nib(1'b1, tx_bytes[0][7:4]);
        send_nib(1'b1, tx_bytes[1][3:0]);
        send_nib(1'b1, tx_bytes[1][7:4]);
        send_nib_rst(1'b1, tx_bytes[2][3:0]);
        check("midrst_tx", 32'(uart_tx), 32'd1);
        check("midrst_led", 32'(LED), 32'h00);
        send_nib(1'b1, tx_bytes[2][7:4]);
        send_bytes(3, 1'b0);
        wait_drain();
        check("midrst_led_after", 32'(LED), 32'h00);
        rx_q.delete();
        send_pre_good();
        send_bytes(0, 1'b0);
        wait_drain();
        check_good("post_rst");
        check("post_rst_led", 32'(LED), 32'h01);

        check("uart_framing", 32'(frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
